// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Vector helpers work on a fixed 32-bit view; callers zero-extend narrower vectors.
package arb_pkg;

    localparam int unsigned MAX_REQ = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Lowest set request at or above the pointer wins; otherwise wrap to the lowest set request.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input logic [MAX_REQ-1:0] ptr);
        logic [MAX_REQ-1:0] masked;
        logic               found;
        int unsigned        win;
        masked = req & ~(ptr - 32'd1);
        found  = 1'b0;
        win    = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (!found && masked[i]) begin
                win   = i;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (!found && req[i]) begin
                win   = i;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_ptr_ring.sv
// One-hot rotating priority pointer; on enable it moves to the slot after idx_i.
module rr_ptr_ring #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_REQ-1:0] ptr_o
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [N_REQ-1:0] ptr_q;
    logic [N_REQ-1:0] ptr_d;

    // Next pointer: one-hot of idx_i+1, wrapping from the last slot back to slot 0
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if (idx_i == IDX_W'(N_REQ - 1)) begin
                ptr_d = ONE;
            end else begin
                ptr_d = ONE << (idx_i + IDX_W'(1));
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ONE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ requesters, with
// release on done, request abort, or optional hold timeout.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 64,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] ptr_s;
    logic [IDX_W-1:0] win_s;
    logic             ptr_en_s;
    logic             abort_s;
    logic             hold_exp_s;
    logic             release_s;

    rr_ptr_ring #(
        .N_REQ (N_REQ)
    ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ptr_en_s),
        .idx_i (idx_q),
        .ptr_o (ptr_s)
    );

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int CNT_W = $clog2(MAX_HOLD + 1);
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Hold counter: cleared while idle, saturating count while busy
            always_comb begin
                cnt_d = cnt_q;
                if (state_q == IDLE) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            // Hold counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign hold_exp_s = (state_q == BUSY) && (cnt_q == CNT_W'(MAX_HOLD - 1));
        end else begin : g_no_hold
            assign hold_exp_s = 1'b0;
        end
    endgenerate

    assign win_s     = IDX_W'(rr_pick(MAX_REQ'(req), MAX_REQ'(ptr_s)));
    assign abort_s   = ~req[idx_q];
    assign release_s = done | abort_s | hold_exp_s;

    // Arbitration and release decisions
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        ptr_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = BUSY;
                    grant_d = ONE << win_s;
                    idx_d   = IDX_W'(onehot_to_idx(MAX_REQ'(ONE << win_s)));
                end else begin
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_en_s  = 1'b1;
                    // done or abort on the same edge makes it a normal release
                    timeout_d = hold_exp_s & ~done & ~abort_s;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule
